// File: rtl/random_ternary_sequencer.sv
// random_ternary_sequencer
//   Produces P ternary coefficients (+1 / -1 / 0) from a 32-bit xorshift
//   generator. Each coefficient goes out on a valid/ready handshake.
//
//   Optional feature macro: RANDOM_TERNARY_WEIGHT_CAP_EN. When it is defined,
//   coefficients are forced to 0 once W nonzero coefficients have been
//   accepted in the current run. The generator keeps stepping.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     start      in   run request, sampled only in IDLE
//     seed[31:0] in   xorshift seed, captured when start is accepted
//     coef_valid out  coef/coef_addr hold a valid coefficient
//     coef_ready in   consumer accepts the current coefficient
//     coef[12:0] out  two's-complement coefficient: 0, +1 or -1
//     coef_addr  out  coefficient index 0..P-1
//     busy       out  high in LOAD and RUN
//     done       out  one-cycle pulse at the end of a run
//     nz_count   out  number of nonzero coefficients accepted this run
module random_ternary_sequencer #(
    parameter int P = 757,
    parameter int W = 286
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [12:0] coef,
    output logic [9:0]  coef_addr,
    output logic        busy,
    output logic        done,
    output logic [9:0]  nz_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

`ifdef RANDOM_TERNARY_WEIGHT_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    localparam logic [9:0] LAST  = 10'(P - 1);
    localparam logic [9:0] W_CAP = 10'(W);

    state_e      state_q, state_d;
    logic [31:0] s_q, s_d;
    logic [31:0] seed_q, seed_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  nz_q, nz_d;
    logic        hs;

    function automatic logic [31:0] xs_step(input logic [31:0] s);
        logic [31:0] t1, t2, t3;
        t1 = s ^ (s >> 7);
        t2 = t1 ^ (t1 << 9);
        t3 = t2 ^ (t2 >> 13);
        return t3 ^ (t3 >> 21);
    endfunction

    // Coefficient decode. It is zero outside RUN, so reset clears it immediately.
    always_comb begin
        coef = '0;
        if (state_q == RUN) begin
            unique case (s_q[1:0])
                2'b01:   coef = 13'd1;
                2'b10:   coef = 13'h1FFF;
                default: coef = '0;
            endcase
            if (CAP_EN && (nz_q >= W_CAP)) begin
                coef = '0;
            end
        end
    end

    assign hs = (state_q == RUN) && coef_ready;

    // The seed is staged in seed_q when start is accepted. s is loaded from
    // seed_q in LOAD, so the final s of the previous run holds through IDLE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        seed_d  = seed_q;
        addr_d  = addr_q;
        nz_d    = nz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d  = seed;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s_d     = (seed_q == '0) ? 32'h1 : seed_q;
                addr_d  = '0;
                nz_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                if (hs) begin
                    s_d = xs_step(s_q);
                    if (coef != '0) begin
                        nz_d = nz_q + 10'd1;
                    end
                    // The last index holds instead of incrementing, so the
                    // address never wraps.
                    if (addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            seed_q  <= '0;
            addr_q  <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            seed_q  <= seed_d;
            addr_q  <= addr_d;
            nz_q    <= nz_d;
        end
    end

    assign coef_valid = (state_q == RUN);
    assign busy       = (state_q == LOAD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign coef_addr  = addr_q;
    assign nz_count   = nz_q;

endmodule

// File: tb/tb_random_ternary_sequencer.sv
module tb_random_ternary_sequencer;

    localparam int P    = 757;
    localparam int WCAP = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        coef_ready = 1'b1;
    logic        coef_valid;
    logic [12:0] coef;
    logic [9:0]  coef_addr;
    logic        busy;
    logic        done;
    logic [9:0]  nz_count;

    always #5 clk = ~clk;

    random_ternary_sequencer #(.P(P), .W(WCAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef       (coef),
        .coef_addr  (coef_addr),
        .busy       (busy),
        .done       (done),
        .nz_count   (nz_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden model: whole coefficient sequence of a run, computed up front.
    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] t1, t2, t3;
        t1 = s ^ (s >> 7);
        t2 = t1 ^ (t1 << 9);
        t3 = t2 ^ (t2 >> 13);
        return t3 ^ (t3 >> 21);
    endfunction

    logic [12:0] gold [P];
    int          gold_nz;

    task automatic gen_gold(input logic [31:0] sd);
        logic [31:0] s;
        logic [12:0] c;
        int          nz;
        s  = (sd == 0) ? 32'h1 : sd;
        nz = 0;
        for (int i = 0; i < P; i++) begin
            if (s[1:0] == 2'b01)      c = 13'd1;
            else if (s[1:0] == 2'b10) c = 13'h1FFF;
            else                      c = 13'd0;
`ifdef RANDOM_TERNARY_WEIGHT_CAP_EN
            if (nz >= WCAP) c = 13'd0;
`endif
            if (c != 0) nz++;
            gold[i] = c;
            s = xs(s);
        end
        gold_nz = nz;
    endtask

    // Per-cycle compare against the model.
    bit          checking = 1'b0;
    bit          rand_ready = 1'b0;
    int          exp_idx, exp_nz, hs_count, done_count, valid_cycles;
    bit          prev_stall;
    logic [12:0] prev_coef;
    logic [9:0]  prev_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (checking) begin
            if (coef_valid) begin
                valid_cycles++;
                if (exp_idx < P) begin
                    check("coef_addr", 32'(coef_addr), 32'(exp_idx));
                    check("coef", 32'(coef), 32'(gold[exp_idx]));
                    check("nz_running", 32'(nz_count), 32'(exp_nz));
                end else begin
                    check("valid_overrun", 32'(exp_idx), 32'(P - 1));
                end
                if (prev_stall) begin
                    check("stall_coef", 32'(coef), 32'(prev_coef));
                    check("stall_addr", 32'(coef_addr), 32'(prev_addr));
                end
                if (coef_ready) begin
                    if (exp_idx < P && gold[exp_idx] != 0) exp_nz++;
                    exp_idx++;
                    hs_count++;
                end
                prev_stall = !coef_ready;
                prev_coef  = coef;
                prev_addr  = coef_addr;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                done_count++;
                check("done_idx", 32'(exp_idx), 32'(P));
                check("done_nz", 32'(nz_count), 32'(exp_nz));
                check("done_valid", 32'(coef_valid), 32'd0);
            end
        end else begin
            check("idle_done", 32'(done), 32'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 coef_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic model_clear();
        exp_idx = 0; exp_nz = 0; hs_count = 0; done_count = 0;
        valid_cycles = 0; prev_stall = 1'b0;
    endtask

    task automatic run(input logic [31:0] sd, input bit rnd, input bit poke);
        int cyc;
        bit seen;
        gen_gold(sd);
        model_clear();
        rand_ready = rnd;
        checking   = 1'b1;
        @(posedge clk);
        #1 start = 1'b1; seed = sd;
        @(posedge clk);
        #1 start = 1'b0; seed = 32'hA5A5_0000;
        check("load_busy", 32'(busy), 32'd1);
        check("load_valid", 32'(coef_valid), 32'd0);
        @(posedge clk);
        #1 check("first_valid", 32'(coef_valid), 32'd1);
        check("first_addr", 32'(coef_addr), 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            if (poke && cyc == 50) begin
                start = 1'b1; seed = 32'h1234_5678;
            end else if (poke && cyc == 53) begin
                start = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("done_once", 32'(done_count), 32'd1);
        check("hs_count", 32'(hs_count), 32'(P));
        if (!rnd) check("run_cycles", 32'(valid_cycles), 32'(P));
        repeat (3) @(posedge clk);
        #1 check("nz_hold", 32'(nz_count), 32'(gold_nz));
        check("idle_valid", 32'(coef_valid), 32'd0);
        rand_ready = 1'b0;
    endtask

    task automatic reset_abort();
        int cyc;
        gen_gold(32'h1);
        model_clear();
        checking = 1'b1;
        @(posedge clk);
        #1 start = 1'b1; seed = 32'h1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (coef_addr != 10'd300 && cyc < 2000);
        check("reach_300", 32'(coef_addr), 32'd300);
        checking = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(coef_valid), 32'd0);
        check("abort_coef", 32'(coef), 32'd0);
        check("abort_addr", 32'(coef_addr), 32'd0);
        check("abort_nz", 32'(nz_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_abort_valid", 32'(coef_valid), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end
    endtask

    int nz_a;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(coef_valid), 32'd0);
        check("rst_coef", 32'(coef), 32'd0);
        check("rst_addr", 32'(coef_addr), 32'd0);
        check("rst_nz", 32'(nz_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Hand-computed: xs(1)=0x201, xs(0x201)=0x40825; all three states end in 01.
        check("mdl_step1", xs(32'h1), 32'h0000_0201);
        check("mdl_step2", xs(32'h201), 32'h0004_0825);
        gen_gold(32'h1);
        check("mdl_g0", 32'(gold[0]), 32'd1);
        check("mdl_g1", 32'(gold[1]), 32'd1);
        check("mdl_g2", 32'(gold[2]), 32'd1);

        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_after_rst", 32'(coef_valid), 32'd0);
        end

        run(32'h1, 1'b0, 1'b0);
        nz_a = int'(nz_count);
`ifdef RANDOM_TERNARY_WEIGHT_CAP_EN
        check("cap_nz", 32'(nz_count), 32'(WCAP));
`endif
        run(32'h0, 1'b0, 1'b0);
        check("seed0_nz_eq", 32'(nz_count), 32'(nz_a));
        run(32'h1, 1'b1, 1'b0);
        run(32'h1, 1'b0, 1'b1);
        reset_abort();
        run(32'h1, 1'b0, 1'b0);
        run(32'hDEAD_BEEF, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/random_ternary_sequencer.md
RANDOM_TERNARY_SEQUENCER -- requirements
Module: random_ternary_sequencer

Interface
REQ-001 SHALL have parameter P, default 757; number of coefficients per run.
REQ-002 SHALL have parameter W, default 286; nonzero-weight cap, used only under REQ-030.
REQ-003 SHALL have port clk, input, 1 bit; single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit; requests one run; sampled only in IDLE.
REQ-006 SHALL have port seed, input, 32 bits; xorshift seed, captured when start is accepted.
REQ-007 SHALL have port coef_valid, output, 1 bit; coef/coef_addr hold a valid coefficient.
REQ-008 SHALL have port coef_ready, input, 1 bit; consumer accepts the coefficient.
REQ-009 SHALL have port coef, output, 13 bits; ternary coefficient, two's complement (0, 13'd1, 13'h1FFF).
REQ-010 SHALL have port coef_addr, output, 10 bits; index 0..P-1 of the coefficient.
REQ-011 SHALL have port busy, output, 1 bit; high in LOAD and RUN.
REQ-012 SHALL have port done, output, 1 bit; one-cycle pulse at run end.
REQ-013 SHALL have port nz_count, output, 10 bits; count of nonzero coefficients accepted this run.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-015 IDLE with start=1 SHALL go to LOAD; start in any other state SHALL be ignored.
REQ-016 LOAD (one cycle) SHALL load 32-bit state s with seed, or 32'h1 when seed==0, clear coef_addr and nz_count, then go to RUN.
REQ-017 Step function SHALL be: t1=s^(s>>7); t2=t1^(t1<<9); t3=t2^(t2>>13); next=t3^(t3>>21); all 32-bit and truncating.
REQ-018 In RUN, coef_valid SHALL be 1, and coef SHALL be a combinational function of s: s[1:0]=01 gives +1, s[1:0]=10 gives -1, 00 or 11 gives 0.
REQ-019 A handshake SHALL be coef_valid & coef_ready in the same cycle.
REQ-020 On a handshake, s SHALL take the next step value, coef_addr SHALL increment, and nz_count SHALL increment if coef!=0.
REQ-021 Without a handshake, s, coef, coef_addr and nz_count SHALL hold (stable under backpressure).
REQ-022 The handshake at coef_addr==P-1 SHALL move to DONE; coef_addr SHALL not wrap to 0 in RUN.
REQ-023 DONE SHALL assert done=1 with coef_valid=0 for exactly one cycle, then return to IDLE.
REQ-024 nz_count and the final s SHALL hold through IDLE until the next LOAD.
REQ-025 Latency: first coef_valid SHALL appear 2 cycles after the start edge; a run with coef_ready held high SHALL take P RUN cycles.
REQ-026 coef_valid SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, s=0, coef_addr=0, nz_count=0, coef_valid=0, busy=0, done=0 and coef=0, including mid-run.
REQ-028 After reset release, the block SHALL emit nothing until a new start.
REQ-029 A run aborted by reset SHALL NOT produce done.

Configuration
REQ-030 With macro RANDOM_TERNARY_WEIGHT_CAP_EN defined, once nz_count==W every further coefficient of the run SHALL be forced to 0 and s SHALL still step on each handshake.
REQ-031 Without RANDOM_TERNARY_WEIGHT_CAP_EN, coef SHALL follow REQ-018 unconditionally, and W SHALL be unused.

Verification
REQ-032 Reset, then a start pulse with seed=32'h1 and coef_ready=1: coef_valid rises 2 cycles later, exactly 757 handshakes occur with coef_addr 0..756, then done pulses once and busy falls.
REQ-033 Run with seed=0, then with seed=1: the two coefficient sequences and nz_count are identical.
REQ-034 Toggle coef_ready pseudo-randomly, 50% duty: the coef sequence matches the coef_ready=1 run, and coef/coef_addr are stable whenever coef_valid=1 and coef_ready=0.
REQ-035 Drop rst_n at coef_addr=300: outputs go to 0 in the same cycle, no done, and the next run after start matches a fresh run.
REQ-036 Under RANDOM_TERNARY_WEIGHT_CAP_EN with W=5 and P=757: final nz_count=5 and all coefficients after the 5th nonzero are 0; without the macro, nz_count matches the golden-model count.
REQ-037 Assert start while busy=1: it is ignored and the sequence is unchanged.
